// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
//   state_e            responder FSM states
//   INSTR_W / ADDR_W   instruction and word-address widths
//   ERR_INSTR          instruction value returned for out-of-range reads
//   addr_out_of_range  true when any address bit above the storage depth is set
package imem_pkg;

  localparam int unsigned INSTR_W            = 16;
  localparam int unsigned ADDR_W             = 16;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 10;

  localparam logic [INSTR_W-1:0] ERR_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // High address bits are checked rather than truncated; a full-width depth has no
  // out-of-range addresses at all.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input int unsigned       depth_log2);
    return (depth_log2 < ADDR_W) && ((addr >> depth_log2) != '0);
  endfunction

endpackage

// File: rtl/imem_if.sv
// imem_if: fetch-side read handshake plus program-load port.
//   req/addr/ready               read request, accepted when req && ready
//   instr/err/valid              response, valid is a one-cycle pulse
//   load_en/load_addr/load_data  program-load write, performed when load_en && load_ready
// master = fetch stage / loader, slave = responder.
interface imem_if;
  import imem_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic               valid;
  logic               err;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;

  modport master (
    output req, addr, load_en, load_addr, load_data,
    input  ready, instr, valid, err, load_ready
  );

  modport slave (
    input  req, addr, load_en, load_addr, load_data,
    output ready, instr, valid, err, load_ready
  );

endinterface

// File: rtl/imem_array.sv
// imem_array: 2^DEPTH_LOG2 x INSTR_W instruction storage.
//   i_clk                      clock for the write port
//   i_we / i_waddr / i_wdata   synchronous write port
//   i_raddr / o_rdata          combinational read port
// Contents are not reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [INSTR_W-1:0]    i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [INSTR_W-1:0]    o_rdata
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [INSTR_W-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: answers word-addressed instruction reads after a fixed LATENCY,
// one request outstanding at a time, and accepts program-load writes when not busy.
//   clk     system clock
//   rst     synchronous active-high reset (storage is retained)
//   io_bus  imem_if slave: read handshake, response, load port
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int unsigned LATENCY    = 3
) (
  input  logic   clk,
  input  logic   rst,
  imem_if.slave  io_bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..15");
  end

  localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

  state_e             r_state;
  logic [3:0]         r_cnt;
  logic [INSTR_W-1:0] r_data;      // response captured at accept
  logic               r_err_pend;  // range check captured at accept
  logic [INSTR_W-1:0] r_instr;
  logic               r_err;
  logic               r_valid;

  logic               w_not_busy;
  logic               w_ready;
  logic               w_accept;
  logic               w_oor;
  logic               w_load_oor;
  logic               w_load_we;
  logic [INSTR_W-1:0] w_rdata;
  logic [INSTR_W-1:0] w_resp_data;

  assign w_not_busy  = (r_state == IDLE) || (r_state == RESP);
  // A load in the same cycle takes priority over a read request.
  assign w_ready     = w_not_busy && !io_bus.load_en;
  assign w_accept    = io_bus.req && w_ready;
  assign w_oor       = addr_out_of_range(io_bus.addr, DEPTH_LOG2);
  assign w_resp_data = w_oor ? ERR_INSTR : w_rdata;
  assign w_load_oor  = addr_out_of_range(io_bus.load_addr, DEPTH_LOG2);
  assign w_load_we   = io_bus.load_en && w_not_busy && !w_load_oor;

  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .i_clk  (clk),
    .i_we   (w_load_we),
    .i_waddr(io_bus.load_addr[DEPTH_LOG2-1:0]),
    .i_wdata(io_bus.load_data),
    .i_raddr(io_bus.addr[DEPTH_LOG2-1:0]),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_data     <= ERR_INSTR;
      r_err_pend <= 1'b0;
      r_instr    <= ERR_INSTR;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_data     <= w_resp_data;
            r_err_pend <= w_oor;
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_valid <= 1'b1;
              r_instr <= w_resp_data;
              r_err   <= w_oor;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LatM1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          // Counter value 1 means this edge lands exactly LATENCY cycles after accept.
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            r_valid <= 1'b1;
            r_instr <= r_data;
            r_err   <= r_err_pend;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.ready      = w_ready;
  assign io_bus.load_ready = w_not_busy;
  assign io_bus.instr      = r_instr;
  assign io_bus.err        = r_err;
  assign io_bus.valid      = r_valid;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder that answers the fetch stage's word-addressed instruction reads over a req/ready/valid handshake.
- Models a fixed multi-cycle memory latency, with one outstanding request at a time.
- Provides a load port so the bench and boot logic can write the program image.
- Sits between the fetch stage (initiator) and the instruction storage.

Parameters:
DEPTH_LOG2, 10, log2 of storage depth in 16-bit words (default 1024 words)
LATENCY, 3, cycles from request accept to valid response; legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req  input  1  fetch read request
addr  input  16  word address (PC) of requested instruction
ready  output  1  request accepted this cycle when req && ready
instr  output  16  returned instruction word
valid  output  1  one-cycle pulse: instr/err carry a response
err  output  1  response was for an out-of-range address
load_en  input  1  program-load write strobe
load_addr  input  16  program-load word address
load_data  input  16  program-load data
load_ready  output  1  load write performed when load_en && load_ready

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On reset: state IDLE, valid=0, err=0, instr=16'h0000, latency counter=0. Storage contents are not cleared.
- States:
  - IDLE: no request in flight.
  - WAIT: counter running.
  - RESP: valid=1 for exactly this cycle.
- Handshake:
  - ready = (state==IDLE || state==RESP) && !load_en. This is combinational.
  - load_ready = (state==IDLE || state==RESP).
- Accept (req && ready at cycle N):
  - Capture mem[addr] into the data register and the range check into the err register at N. Later loads do not alter the in-flight response.
  - valid asserts at cycle N+LATENCY.
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to WAIT with counter=LATENCY-1. Decrement each cycle; move to RESP when counter reaches 1.
- Leaving RESP:
  - If a new request is accepted in RESP: proceed as for an accept from IDLE.
  - Else: return to IDLE.
  - With LATENCY=1 and req held high, valid pulses every cycle.
- instr and err hold their last response value after valid falls.
- Range check:
  - Out of range when addr[15:DEPTH_LOG2] != 0.
  - Out-of-range response: instr=16'h0000, err=1. Storage is not read.
- Load writes:
  - Write when load_en && load_ready. Write mem[load_addr[DEPTH_LOG2-1:0]] = load_data at the clock edge.
  - Out-of-range load_addr: the write is dropped silently.
- Simultaneous events:
  - load_en && req in IDLE/RESP: the load wins and req is not accepted that cycle.
  - load_en in WAIT: ignored (load_ready=0), no write.
- Reset mid-operation: any pending response is dropped. No late valid after reset deasserts.
- Width rules: all addresses are word addresses. There is no byte addressing and no address wrap; high bits are checked, not truncated, for reads.

Decomposition:
- Package imem_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - INSTR_W=16, ADDR_W=16
  - ERR_INSTR=16'h0000
  - default DEPTH_LOG2
- One sub-module, imem_array: 2^DEPTH_LOG2 x 16 storage with one synchronous write port and one combinational read port.
- The FSM, counter and range check live in imem_responder.

Test Plan:
1. Read latency:
   - Stimulus: after rst, load words 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444, then req addr=2 accepted at cycle N.
   - Required: valid=1 only at N+3 with instr=16'h3333, err=0; ready=0 at N+1 and N+2; instr still 16'h3333 at N+4.
2. Back-to-back reads:
   - Stimulus: req held high, addr=0 then addr=1 presented in the RESP cycle.
   - Required: second request accepted in RESP; valid pulses 3 cycles apart carrying 16'h1111 then 16'h2222.
3. Load/request collision:
   - Stimulus: in IDLE, load_en=1 (addr 5, data 16'hBEEF) and req=1 (addr 5) in the same cycle.
   - Required: ready=0 and the write happens; the req is accepted next cycle; the response is 16'hBEEF.
4. Load during WAIT:
   - Stimulus: load_en=1 to addr 2 with 16'h0F0F while in WAIT.
   - Required: load_ready=0; the in-flight response is unchanged; a subsequent read of addr 2 returns 16'h3333.
5. Out-of-range read:
   - Stimulus: req addr=16'h0400 with DEPTH_LOG2=10.
   - Required: valid at N+3 with err=1 and instr=16'h0000; the next in-range read returns err=0.
6. Reset mid-request:
   - Stimulus: assert rst for one cycle during WAIT.
   - Required: the cycle after reset has valid=0, ready=1 and state IDLE; no valid follows; loaded storage is retained (addr 0 still reads 16'h1111).
   - Repeat the latency check of test 1 with LATENCY=1: valid at N+1.
